// File: rtl/spi_hedef_birimi.sv
// SPI target: synchronized pads, modes 0-3, MSB/LSB first, one-word TX holding register with same-cycle bypass.
// rx_data_o/rx_valid_o one cycle after the last sample edge; tx_ready_o low while holding is full, no other backpressure.
`timescale 1ns/1ps
module spi_hedef_birimi #(
    parameter int TXN_W  = 8,
    parameter int SYNC_N = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic             msb_first_i,
    input  logic [TXN_W-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [TXN_W-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             tx_underrun_o,
    output logic             frame_abort_o,
    output logic             busy_o,
    input  logic             sck_i,
    input  logic             csn_i,
    input  logic             mosi_i,
    output logic             miso_o,
    output logic             miso_oe_o
);
    localparam int CNT_W = $clog2(TXN_W);

    typedef enum logic {BOSTA, KAYDIR} state_t;

    state_t             state_q, state_d;
    logic [SYNC_N-1:0]  sck_sync_q, sck_sync_d;
    logic [SYNC_N-1:0]  csn_sync_q, csn_sync_d;
    logic [SYNC_N-1:0]  mosi_sync_q, mosi_sync_d;
    logic               sck_prev_q, sck_prev_d;
    logic               csn_prev_q, csn_prev_d;
    logic               cpol_q, cpol_d;
    logic               cpha_q, cpha_d;
    logic               msb_q, msb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sampled_q, sampled_d;
    logic               done_q, done_d;
    logic               urun_pend_q, urun_pend_d;
    logic [TXN_W-1:0]   tx_sr_q, tx_sr_d;
    logic [TXN_W-1:0]   rx_sr_q, rx_sr_d;
    logic [TXN_W-1:0]   rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               urun_q, urun_d;
    logic               abort_q, abort_d;
    logic [TXN_W-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;

    logic               sck_s, csn_s, mosi_s;
    logic               sck_rise, sck_fall, csn_fall, csn_rise;
    logic               samp_edge, shift_edge;
    logic               load_now, load_zero;
    logic [TXN_W-1:0]   load_word;

    always_comb begin
        sck_s      = sck_sync_q[SYNC_N-1];
        csn_s      = csn_sync_q[SYNC_N-1];
        mosi_s     = mosi_sync_q[SYNC_N-1];
        sck_rise   = sck_s & ~sck_prev_q;
        sck_fall   = ~sck_s & sck_prev_q;
        csn_fall   = ~csn_s & csn_prev_q;
        csn_rise   = csn_s & ~csn_prev_q;
        // Sample on rising sck for modes 0/3, falling for modes 1/2.
        samp_edge  = (cpol_q ^ cpha_q) ? sck_fall : sck_rise;
        shift_edge = (cpol_q ^ cpha_q) ? sck_rise : sck_fall;

        load_zero = 1'b0;
        if (hold_full_q) begin
            load_word = hold_q;
        end else if (tx_valid_i) begin
            load_word = tx_data_i;
        end else begin
            load_word = '0;
            load_zero = 1'b1;
        end

        sck_sync_d  = {sck_sync_q[SYNC_N-2:0], sck_i};
        csn_sync_d  = {csn_sync_q[SYNC_N-2:0], csn_i};
        mosi_sync_d = {mosi_sync_q[SYNC_N-2:0], mosi_i};
        sck_prev_d  = sck_s;
        csn_prev_d  = csn_s;

        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        msb_d       = msb_q;
        cnt_d       = cnt_q;
        sampled_d   = sampled_q;
        done_d      = done_q;
        urun_pend_d = urun_pend_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rx_data_d   = rx_data_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_valid_d  = 1'b0;
        urun_d      = 1'b0;
        abort_d     = 1'b0;
        load_now    = 1'b0;

        case (state_q)
            BOSTA: begin
                if (csn_fall) begin
                    state_d   = KAYDIR;
                    cpol_d    = cpol_i;
                    cpha_d    = cpha_i;
                    msb_d     = msb_first_i;
                    cnt_d     = '0;
                    rx_sr_d   = '0;
                    load_now  = 1'b1;
                end
            end
            KAYDIR: begin
                if (csn_rise) begin
                    state_d     = BOSTA;
                    abort_d     = (cnt_q != '0);
                    cnt_d       = '0;
                    sampled_d   = 1'b0;
                    done_d      = 1'b0;
                    urun_pend_d = 1'b0;
                    tx_sr_d     = '0;
                    rx_sr_d     = '0;
                end else if (samp_edge) begin
                    rx_sr_d   = msb_q ? {rx_sr_q[TXN_W-2:0], mosi_s}
                                      : {mosi_s, rx_sr_q[TXN_W-1:1]};
                    sampled_d = 1'b1;
                    if (urun_pend_q) begin
                        urun_d      = 1'b1;
                        urun_pend_d = 1'b0;
                    end
                    if (cnt_q == CNT_W'(TXN_W-1)) begin
                        cnt_d      = '0;
                        rx_data_d  = rx_sr_d;
                        rx_valid_d = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge) begin
                    // Shift edges before the first sample of a word (CPHA=1 lead-in) keep bit 0 on miso.
                    if (done_q) begin
                        load_now = 1'b1;
                    end else if (sampled_q) begin
                        tx_sr_d = msb_q ? {tx_sr_q[TXN_W-2:0], 1'b0}
                                        : {1'b0, tx_sr_q[TXN_W-1:1]};
                    end
                end
            end
            default: state_d = BOSTA;
        endcase

        if (load_now) begin
            tx_sr_d     = load_word;
            urun_pend_d = load_zero;
            sampled_d   = 1'b0;
            done_d      = 1'b0;
        end

        // A bypass load consumes tx_data_i directly, so the holding register is not written that cycle.
        if (load_now && hold_full_q) begin
            hold_full_d = 1'b0;
        end else if (!load_now && tx_valid_i && !hold_full_q) begin
            hold_d      = tx_data_i;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= BOSTA;
            sck_sync_q  <= '0;
            csn_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            csn_prev_q  <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            msb_q       <= 1'b0;
            cnt_q       <= '0;
            sampled_q   <= 1'b0;
            done_q      <= 1'b0;
            urun_pend_q <= 1'b0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            urun_q      <= 1'b0;
            abort_q     <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            csn_sync_q  <= csn_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            csn_prev_q  <= csn_prev_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            msb_q       <= msb_d;
            cnt_q       <= cnt_d;
            sampled_q   <= sampled_d;
            done_q      <= done_d;
            urun_pend_q <= urun_pend_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            urun_q      <= urun_d;
            abort_q     <= abort_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign busy_o        = (state_q == KAYDIR);
    assign miso_oe_o     = busy_o;
    assign miso_o        = busy_o & (msb_q ? tx_sr_q[TXN_W-1] : tx_sr_q[0]);
    assign tx_ready_o    = ~hold_full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_underrun_o = urun_q;
    assign frame_abort_o = abort_q;

endmodule

// File: tb/tb_spi_hedef_birimi.sv
// Bench for spi_hedef_birimi: table of single-word frames plus hand-written multi-word, abort, reset and bypass sequences.
`timescale 1ns/1ps
module tb_spi_hedef_birimi;
    localparam int W  = 8;
    localparam int SN = 2;
    localparam int HP = 8;

    logic         clk = 1'b0;
    logic         rst_i, cpol_i, cpha_i, msb_first_i, tx_valid_i;
    logic [W-1:0] tx_data_i;
    logic         tx_ready_o, rx_valid_o, tx_underrun_o, frame_abort_o, busy_o;
    logic [W-1:0] rx_data_o;
    logic         sck_i, csn_i, mosi_i, miso_o, miso_oe_o;

    always #5 clk = ~clk;

    spi_hedef_birimi #(.TXN_W(W), .SYNC_N(SN)) dut (
        .clk_i(clk), .rst_i(rst_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
        .msb_first_i(msb_first_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .tx_underrun_o(tx_underrun_o), .frame_abort_o(frame_abort_o), .busy_o(busy_o),
        .sck_i(sck_i), .csn_i(csn_i), .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe_o(miso_oe_o)
    );

    int n_checks = 0, n_fail = 0;
    int n_rxv = 0, n_urun = 0, n_abort = 0, n_notready = 0;
    logic [W-1:0] rx_exp_q[$];
    logic [W-1:0] last_rx_exp = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard for received words plus pulse counters.
    always @(negedge clk) begin : mon
        logic [W-1:0] e;
        if (rx_valid_o) begin
            n_rxv++;
            if (rx_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got %0h, nothing expected", rx_data_o);
            end else begin
                e = rx_exp_q.pop_front();
                last_rx_exp = e;
                check("rx_data", {24'd0, rx_data_o}, {24'd0, e});
            end
        end
        if (tx_underrun_o) n_urun++;
        if (frame_abort_o) n_abort++;
        if (!tx_ready_o)   n_notready++;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [W-1:0] d);
        int t;
        t = 0;
        while (!tx_ready_o && t < 100) begin
            clks(1);
            t++;
        end
        check("preload_ready", {31'd0, tx_ready_o}, 32'd1);
        tx_valid_i = 1'b1; tx_data_i = d;
        clks(1);
        tx_valid_i = 1'b0;
        check("hold_full", {31'd0, tx_ready_o}, 32'd0);
        // Write while full must be ignored.
        tx_valid_i = 1'b1; tx_data_i = ~d;
        clks(1);
        tx_valid_i = 1'b0;
    endtask

    task automatic frame_start(input logic cpol, input logic cpha, input logic msb);
        cpol_i = cpol; cpha_i = cpha; msb_first_i = msb;
        sck_i = cpol; mosi_i = 1'b0;
        clks(HP);
        csn_i = 1'b0;
        clks(HP);
    endtask

    task automatic frame_end();
        clks(HP);
        csn_i = 1'b1;
        clks(2 * HP);
    endtask

    task automatic xfer(input logic cpol, input logic cpha, input logic msb,
                        input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi);
        int bi;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            bi = msb ? W - 1 - i : i;
            if (!cpha) begin
                mosi_i = mo[bi];
                clks(HP);
                mi[bi] = miso_o;
                sck_i = ~cpol;
                clks(HP);
                sck_i = cpol;
            end else begin
                sck_i = ~cpol;
                mosi_i = mo[bi];
                clks(HP);
                mi[bi] = miso_o;
                sck_i = cpol;
                clks(HP);
            end
        end
    endtask

    typedef struct {
        logic       cpol, cpha, msb, pre;
        logic [7:0] tx, mo, exp_mi;
        int         exp_urun;
    } vec_t;

    vec_t vt[5];

    initial begin : wdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1);
    end

    initial begin : main
        int rv0, u0, a0, nr0;
        logic [W-1:0] mi, mi2;

        vt[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 8'hC3, 8'h5A, 0};
        vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 8'hF0, 8'h0F, 0};
        vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 8'h12, 8'h81, 0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h55, 8'h00, 1};

        rst_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0; msb_first_i = 1'b1;
        tx_valid_i = 1'b0; tx_data_i = '0;
        sck_i = 1'b0; csn_i = 1'b1; mosi_i = 1'b0;
        clks(3);
        check("rst_busy",     {31'd0, busy_o},     32'd0);
        check("rst_miso_oe",  {31'd0, miso_oe_o},  32'd0);
        check("rst_miso",     {31'd0, miso_o},     32'd0);
        check("rst_tx_ready", {31'd0, tx_ready_o}, 32'd1);
        check("rst_rx_data",  {24'd0, rx_data_o},  32'd0);
        rst_i = 1'b0;
        clks(SN + 3);

        for (int k = 0; k < 5; k++) begin
            rv0 = n_rxv; u0 = n_urun; a0 = n_abort;
            if (vt[k].pre) preload(vt[k].tx);
            frame_start(vt[k].cpol, vt[k].cpha, vt[k].msb);
            check($sformatf("v%0d_busy", k),    {31'd0, busy_o},    32'd1);
            check($sformatf("v%0d_miso_oe", k), {31'd0, miso_oe_o}, 32'd1);
            rx_exp_q.push_back(vt[k].mo);
            xfer(vt[k].cpol, vt[k].cpha, vt[k].msb, vt[k].mo, 8, mi);
            frame_end();
            check($sformatf("v%0d_miso_word", k), {24'd0, mi}, {24'd0, vt[k].exp_mi});
            check($sformatf("v%0d_rx_pulses", k), n_rxv - rv0, 1);
            check($sformatf("v%0d_underrun", k),  n_urun - u0, vt[k].exp_urun);
            check($sformatf("v%0d_abort", k),     n_abort - a0, 0);
            check($sformatf("v%0d_idle", k),      {30'd0, busy_o, miso_oe_o}, 32'd0);
        end

        // Mode 3, LSB first, two words in one frame; second tx word written while busy.
        rv0 = n_rxv; u0 = n_urun; a0 = n_abort;
        preload(8'h81);
        frame_start(1'b1, 1'b1, 1'b0);
        cpol_i = 1'b0; cpha_i = 1'b0; msb_first_i = 1'b1;
        clks(4);
        preload(8'h7E);
        rx_exp_q.push_back(8'h12);
        xfer(1'b1, 1'b1, 1'b0, 8'h12, 8, mi);
        rx_exp_q.push_back(8'h34);
        xfer(1'b1, 1'b1, 1'b0, 8'h34, 8, mi2);
        frame_end();
        check("two_word_miso0",   {24'd0, mi},  32'h81);
        check("two_word_miso1",   {24'd0, mi2}, 32'h7E);
        check("two_word_rx",      n_rxv - rv0, 2);
        check("two_word_urun",    n_urun - u0, 0);
        check("two_word_abort",   n_abort - a0, 0);

        // csn raised after 5 of 8 bits.
        rv0 = n_rxv; a0 = n_abort;
        preload(8'h5C);
        frame_start(1'b0, 1'b0, 1'b1);
        xfer(1'b0, 1'b0, 1'b1, 8'hB7, 5, mi);
        frame_end();
        check("abort_pulse",   n_abort - a0, 1);
        check("abort_no_rx",   n_rxv - rv0, 0);
        check("abort_rx_keep", {24'd0, rx_data_o}, {24'd0, last_rx_exp});

        // Reset at bit 3 of a mode 2 word, csn held low, then a fresh frame.
        a0 = n_abort;
        preload(8'hC6);
        frame_start(1'b1, 1'b0, 1'b1);
        xfer(1'b1, 1'b0, 1'b1, 8'h99, 3, mi);
        rst_i = 1'b1;
        clks(2);
        rst_i = 1'b0;
        check("midrst_busy",     {31'd0, busy_o},     32'd0);
        check("midrst_miso_oe",  {31'd0, miso_oe_o},  32'd0);
        check("midrst_miso",     {31'd0, miso_o},     32'd0);
        check("midrst_tx_ready", {31'd0, tx_ready_o}, 32'd1);
        check("midrst_rx_data",  {24'd0, rx_data_o},  32'd0);
        clks(10);
        check("midrst_wait_idle", {31'd0, busy_o}, 32'd0);
        frame_end();
        rv0 = n_rxv;
        preload(8'h3A);
        frame_start(1'b1, 1'b0, 1'b1);
        rx_exp_q.push_back(8'hE1);
        xfer(1'b1, 1'b0, 1'b1, 8'hE1, 8, mi);
        frame_end();
        check("post_rst_miso",  {24'd0, mi}, 32'h3A);
        check("post_rst_rx",    n_rxv - rv0, 1);
        check("post_rst_abort", n_abort - a0, 0);

        // tx_valid_i in the csn-fall load cycle with holding empty: bypass.
        rv0 = n_rxv; u0 = n_urun;
        check("bypass_pre_ready", {31'd0, tx_ready_o}, 32'd1);
        cpol_i = 1'b0; cpha_i = 1'b0; msb_first_i = 1'b1;
        sck_i = 1'b0; mosi_i = 1'b0;
        clks(HP);
        nr0 = n_notready;
        csn_i = 1'b0;
        clks(SN);
        tx_valid_i = 1'b1; tx_data_i = 8'h96;
        clks(1);
        tx_valid_i = 1'b0;
        clks(HP);
        rx_exp_q.push_back(8'h69);
        xfer(1'b0, 1'b0, 1'b1, 8'h69, 8, mi);
        frame_end();
        check("bypass_miso",     {24'd0, mi}, 32'h96);
        check("bypass_urun",     n_urun - u0, 0);
        check("bypass_ready_hi", n_notready - nr0, 0);
        check("bypass_rx",       n_rxv - rv0, 1);

        clks(5);
        check("rx_queue_empty", rx_exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
